line_accumulator: RTL

//  Downstream neighbour of the line adder tree. Consumes one line sum per valid

---
 rtl/line_accumulator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/line_accumulator.sv
// line_accumulator
//   Accumulates NUM_LINES consecutive line sums from the adder tree into one
//   block total and presents it on a valid/ready output with one-entry holding.
//   A line sum offered while the held total is stalled is dropped and flagged
//   in a sticky error bit.
module line_accumulator #(
  parameter  int PIXEL_SIZE = 8,
  parameter  int LINE_SIZE  = 16,
  parameter  int NUM_LINES  = 8,
  localparam int SUM_W      = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
  localparam int ACC_W      = SUM_W + $clog2(NUM_LINES),
  localparam int CNT_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] line_sum_in,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] line_cnt,
  output logic             err_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Count value at which the incoming sum completes the group.
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_LINES - 1);
  localparam bit               SINGLE_LN = (NUM_LINES == 1);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ACC_W-1:0] out_sum_reg, out_sum_next;
  logic             out_valid_reg, out_valid_next;
  logic             err_reg, err_next;

  logic             accept;
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_plus;

  // Ready whenever no total is stalled; a draining total frees the slot in the same cycle.
  assign in_ready = (state_reg != HOLD) | out_ready;
  assign accept   = in_valid & in_ready;
  assign sum_ext  = ACC_W'(line_sum_in);
  assign acc_plus = acc_reg + sum_ext;

  assign out_sum   = out_sum_reg;
  assign out_valid = out_valid_reg;
  assign line_cnt  = cnt_reg;
  assign err_drop  = err_reg;

  // State and datapath registers; reset discards any partial group.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_sum_reg   <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      out_sum_reg   <= out_sum_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic: clear dominates, then drop flagging, then the group FSM.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    out_sum_next   = out_sum_reg;
    out_valid_next = out_valid_reg;
    err_next       = err_reg;

    if (clear) begin
      state_next     = IDLE;
      acc_next       = '0;
      cnt_next       = '0;
      out_sum_next   = '0;
      out_valid_next = 1'b0;
      err_next       = 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        err_next = 1'b1;
      end

      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_next = sum_ext;
            if (SINGLE_LN) begin
              out_sum_next   = sum_ext;
              out_valid_next = 1'b1;
              cnt_next       = '0;
              state_next     = HOLD;
            end else begin
              cnt_next   = CNT_W'(1);
              state_next = ACCUM;
            end
          end
        end

        ACCUM: begin
          if (accept) begin
            acc_next = acc_plus;
            if (cnt_reg == LAST_CNT) begin
              out_sum_next   = acc_plus;
              out_valid_next = 1'b1;
              cnt_next       = '0;
              state_next     = HOLD;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
            // A sum arriving while the total drains opens the next group.
            if (accept) begin
              acc_next = sum_ext;
              if (SINGLE_LN) begin
                out_sum_next   = sum_ext;
                out_valid_next = 1'b1;
                cnt_next       = '0;
                state_next     = HOLD;
              end else begin
                cnt_next   = CNT_W'(1);
                state_next = ACCUM;
              end
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
